// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle MIPS-subset controller.
// Holds the state encodings, opcode/funct constants, ALU operation codes,
// datapath mux select constants, the instruction class enum produced by
// ctrl_decode and the packed bundle of control outputs.
package ctrl_pkg;

    // FSM state encodings (5 bits, exported on state_dbg). RESET is zero so
    // that state_dbg also reads zero while reset is held.
    localparam logic [4:0] S_RESET      = 5'd0;
    localparam logic [4:0] S_FETCH      = 5'd1;
    localparam logic [4:0] S_FETCH_WAIT = 5'd2;
    localparam logic [4:0] S_DECODE     = 5'd3;
    localparam logic [4:0] S_EXEC_R     = 5'd4;
    localparam logic [4:0] S_WB_R       = 5'd5;
    localparam logic [4:0] S_ADDI_EX    = 5'd6;
    localparam logic [4:0] S_ADDI_WB    = 5'd7;
    localparam logic [4:0] S_ADDR       = 5'd8;
    localparam logic [4:0] S_SW_MEM     = 5'd9;
    localparam logic [4:0] S_LW_MEM     = 5'd10;
    localparam logic [4:0] S_LW_WAIT    = 5'd11;
    localparam logic [4:0] S_LW_WB      = 5'd12;
    localparam logic [4:0] S_BRANCH     = 5'd13;
    localparam logic [4:0] S_JUMP       = 5'd14;
    localparam logic [4:0] S_BAD_OP     = 5'd15;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // ula32 operation codes
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    // alu_src_b selects
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // pc_src selects
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // reg_dst selects
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_SP = 2'd2;

    // mem_to_reg selects
    localparam logic [1:0] M2R_ALUOUT  = 2'd0;
    localparam logic [1:0] M2R_MDR     = 2'd1;
    localparam logic [1:0] M2R_SP_INIT = 2'd2;

    typedef enum logic [3:0] {
        CL_R_ADD,
        CL_R_SUB,
        CL_R_AND,
        CL_ADDI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_BNE,
        CL_J,
        CL_ILLEGAL
    } instr_class_t;

    // All controller outputs except state_dbg, so they can be defaulted and
    // forced to zero as one unit.
    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       ab_write;
        logic       aluout_write;
        logic       mdr_write;
        logic       mem_addr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       exc_ovf;
        logic       exc_opcode;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction classifier.
// Ports:
//   opcode      in  IR[31:26]
//   funct       in  IR[5:0]
//   instr_class out class used by the FSM to pick its path
// Any opcode outside the supported subset, and any R-type funct other than
// add/sub/and, classifies as CL_ILLEGAL.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = CL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  instr_class = CL_R_ADD;
                    FN_SUB:  instr_class = CL_R_SUB;
                    FN_AND:  instr_class = CL_R_AND;
                    default: instr_class = CL_ILLEGAL;
                endcase
            end
            OP_ADDI: instr_class = CL_ADDI;
            OP_LW:   instr_class = CL_LW;
            OP_SW:   instr_class = CL_SW;
            OP_BEQ:  instr_class = CL_BEQ;
            OP_BNE:  instr_class = CL_BNE;
            OP_J:    instr_class = CL_J;
            default: instr_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo: multicycle control FSM for the MIPS-subset datapath.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   opcode, funct         from the instruction register
//   alu_zero, alu_ovf     ula32 flags
//   *_write               datapath load enables
//   mem_addr_src, alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg
//                         datapath mux selects / ALU operation
//   exc_ovf, exc_opcode   one-cycle exception pulses
//   state_dbg             current state encoding
// SP_INIT / SP_REG are the value and register the datapath uses when
// mem_to_reg / reg_dst select the stack-pointer init path in RESET.
module ctrl_multiciclo
    import ctrl_pkg::*;
#(
    parameter int SP_INIT = 227,
    parameter int SP_REG  = 29
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    output logic       pc_write,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       mdr_write,
    output logic       mem_addr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       exc_ovf,
    output logic       exc_opcode,
    output logic [4:0] state_dbg
);

    if (SP_REG < 0 || SP_REG > 31 || SP_INIT < 0) begin : g_bad_params
        $error("ctrl_multiciclo: SP_REG must be 0..31 and SP_INIT non-negative");
    end

    logic [4:0]   state_reg;
    logic [4:0]   state_next;
    logic         ovf_q;
    instr_class_t instr_class;
    ctrl_t        ctrl;

    ctrl_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .instr_class (instr_class)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_RESET;
            ovf_q     <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Overflow is only meaningful for add/sub; and always clears it
            // so a stale flag can never suppress its write-back.
            if (state_reg == S_EXEC_R) begin
                ovf_q <= alu_ovf && (instr_class == CL_R_ADD || instr_class == CL_R_SUB);
            end else if (state_reg == S_ADDI_EX) begin
                ovf_q <= alu_ovf;
            end
        end
    end

    always_comb begin
        ctrl       = '0;
        state_next = state_reg;
        case (state_reg)
            S_RESET: begin
                ctrl.reg_dst    = REGDST_SP;
                ctrl.mem_to_reg = M2R_SP_INIT;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
            S_FETCH: begin
                // Present PC to memory; data arrives next cycle.
                state_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
                state_next     = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.ab_write     = 1'b1;
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_IMM_SH;
                ctrl.alu_op       = ALU_ADD;
                ctrl.aluout_write = 1'b1;
                case (instr_class)
                    CL_R_ADD, CL_R_SUB, CL_R_AND: state_next = S_EXEC_R;
                    CL_ADDI:                      state_next = S_ADDI_EX;
                    CL_LW, CL_SW:                 state_next = S_ADDR;
                    CL_BEQ, CL_BNE:               state_next = S_BRANCH;
                    CL_J:                         state_next = S_JUMP;
                    default:                      state_next = S_BAD_OP;
                endcase
            end
            S_EXEC_R: begin
                ctrl.alu_src_b    = SRCB_B;
                ctrl.aluout_write = 1'b1;
                case (instr_class)
                    CL_R_SUB: ctrl.alu_op = ALU_SUB;
                    CL_R_AND: ctrl.alu_op = ALU_AND;
                    default:  ctrl.alu_op = ALU_ADD;
                endcase
                state_next = S_WB_R;
            end
            S_WB_R: begin
                ctrl.reg_dst    = REGDST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.reg_write  = !ovf_q;
                ctrl.exc_ovf    = ovf_q;
                state_next      = S_FETCH;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_b    = SRCB_IMM;
                ctrl.alu_op       = ALU_ADD;
                ctrl.aluout_write = 1'b1;
                state_next        = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.reg_write  = !ovf_q;
                ctrl.exc_ovf    = ovf_q;
                state_next      = S_FETCH;
            end
            S_ADDR: begin
                ctrl.alu_src_b    = SRCB_IMM;
                ctrl.alu_op       = ALU_ADD;
                ctrl.aluout_write = 1'b1;
                state_next        = (instr_class == CL_LW) ? S_LW_MEM : S_SW_MEM;
            end
            S_SW_MEM: begin
                ctrl.mem_addr_src = 1'b1;
                ctrl.mem_write    = 1'b1;
                state_next        = S_FETCH;
            end
            S_LW_MEM: begin
                ctrl.mem_addr_src = 1'b1;
                state_next        = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                // Address held for the second cycle while MDR captures data.
                ctrl.mem_addr_src = 1'b1;
                ctrl.mdr_write    = 1'b1;
                state_next        = S_LW_WB;
            end
            S_LW_WB: begin
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_write  = (instr_class == CL_BNE) ? !alu_zero : alu_zero;
                state_next     = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                state_next    = S_FETCH;
            end
            S_BAD_OP: begin
                // PC was already advanced in FETCH_WAIT; just flag and move on.
                ctrl.exc_opcode = 1'b1;
                state_next      = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset is asynchronous, so the outputs are forced low combinationally
    // for as long as it is held (RESET's reg_write must not fire early).
    ctrl_t ctrl_out;
    assign ctrl_out = reset ? '0 : ctrl;

    assign pc_write     = ctrl_out.pc_write;
    assign mem_write    = ctrl_out.mem_write;
    assign ir_write     = ctrl_out.ir_write;
    assign reg_write    = ctrl_out.reg_write;
    assign ab_write     = ctrl_out.ab_write;
    assign aluout_write = ctrl_out.aluout_write;
    assign mdr_write    = ctrl_out.mdr_write;
    assign mem_addr_src = ctrl_out.mem_addr_src;
    assign alu_src_a    = ctrl_out.alu_src_a;
    assign alu_src_b    = ctrl_out.alu_src_b;
    assign alu_op       = ctrl_out.alu_op;
    assign pc_src       = ctrl_out.pc_src;
    assign reg_dst      = ctrl_out.reg_dst;
    assign mem_to_reg   = ctrl_out.mem_to_reg;
    assign exc_ovf      = ctrl_out.exc_ovf;
    assign exc_opcode   = ctrl_out.exc_opcode;
    assign state_dbg    = state_reg;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Testbench for ctrl_multiciclo. Each instruction's expected per-cycle
// outputs are generated from the instruction rules and queued; a monitor
// compares the DUT against the queue on every falling edge.
module tb_ctrl_multiciclo;
    import ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       alu_ovf = 1'b0;
    logic       pc_write, mem_write, ir_write, reg_write, ab_write;
    logic       aluout_write, mdr_write, mem_addr_src, alu_src_a;
    logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
    logic [2:0] alu_op;
    logic       exc_ovf, exc_opcode;
    logic [4:0] state_dbg;

    typedef struct packed {
        logic [4:0] st;
        logic       pc_write;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       ab_write;
        logic       aluout_write;
        logic       mdr_write;
        logic       mem_addr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       exc_ovf;
        logic       exc_opcode;
    } obs_t;

    obs_t act;
    assign act = {state_dbg, pc_write, mem_write, ir_write, reg_write, ab_write,
                  aluout_write, mdr_write, mem_addr_src, alu_src_a, alu_src_b,
                  alu_op, pc_src, reg_dst, mem_to_reg, exc_ovf, exc_opcode};

    obs_t exp_q[$];
    obs_t inst_q[$];
    bit   z_arr[7];
    bit   o_arr[7];
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    ctrl_multiciclo #(.SP_INIT(227), .SP_REG(29)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .pc_write(pc_write), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .ab_write(ab_write), .aluout_write(aluout_write),
        .mdr_write(mdr_write), .mem_addr_src(mem_addr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .exc_ovf(exc_ovf), .exc_opcode(exc_opcode),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    function automatic obs_t blank(input logic [4:0] s);
        obs_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    // Reference: expected outputs for every cycle of one instruction, given
    // the zero/overflow flag values presented during each cycle.
    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        obs_t e;
        bit is_r;
        bit arith;
        inst_q.delete();
        inst_q.push_back(blank(S_FETCH));
        e = blank(S_FETCH_WAIT);
        e.ir_write = 1; e.alu_src_a = 1; e.alu_src_b = 2'd1; e.alu_op = 3'b001; e.pc_write = 1;
        inst_q.push_back(e);
        e = blank(S_DECODE);
        e.ab_write = 1; e.alu_src_a = 1; e.alu_src_b = 2'd3; e.alu_op = 3'b001; e.aluout_write = 1;
        inst_q.push_back(e);
        is_r = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        if (is_r) begin
            e = blank(S_EXEC_R);
            e.aluout_write = 1;
            e.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            inst_q.push_back(e);
            arith = (fn != 6'h24) && o_arr[3];
            e = blank(S_WB_R);
            e.reg_dst = 2'd1; e.reg_write = !arith; e.exc_ovf = arith;
            inst_q.push_back(e);
        end else if (op == 6'h08) begin
            e = blank(S_ADDI_EX);
            e.alu_src_b = 2'd2; e.alu_op = 3'b001; e.aluout_write = 1;
            inst_q.push_back(e);
            e = blank(S_ADDI_WB);
            e.reg_write = !o_arr[3]; e.exc_ovf = o_arr[3];
            inst_q.push_back(e);
        end else if (op == 6'h23 || op == 6'h2B) begin
            e = blank(S_ADDR);
            e.alu_src_b = 2'd2; e.alu_op = 3'b001; e.aluout_write = 1;
            inst_q.push_back(e);
            if (op == 6'h2B) begin
                e = blank(S_SW_MEM);
                e.mem_addr_src = 1; e.mem_write = 1;
                inst_q.push_back(e);
            end else begin
                e = blank(S_LW_MEM);
                e.mem_addr_src = 1;
                inst_q.push_back(e);
                e = blank(S_LW_WAIT);
                e.mem_addr_src = 1; e.mdr_write = 1;
                inst_q.push_back(e);
                e = blank(S_LW_WB);
                e.mem_to_reg = 2'd1; e.reg_write = 1;
                inst_q.push_back(e);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            e = blank(S_BRANCH);
            e.alu_op = 3'b010; e.pc_src = 2'd1;
            e.pc_write = (op == 6'h04) ? z_arr[3] : !z_arr[3];
            inst_q.push_back(e);
        end else if (op == 6'h02) begin
            e = blank(S_JUMP);
            e.pc_src = 2'd2; e.pc_write = 1;
            inst_q.push_back(e);
        end else begin
            e = blank(S_BAD_OP);
            e.exc_opcode = 1;
            inst_q.push_back(e);
        end
    endtask

    // zv/ov: 0 or 1 forces that flag in every cycle, -1 randomises per cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zv, input int ov);
        int n;
        for (int c = 0; c < 7; c++) begin
            z_arr[c] = (zv < 0) ? bit'($urandom_range(0, 1)) : bit'(zv);
            o_arr[c] = (ov < 0) ? bit'($urandom_range(0, 1)) : bit'(ov);
        end
        build(op, fn);
        n = inst_q.size();
        $display("instr op=%02h funct=%02h zero@3=%0d ovf@3=%0d cycles=%0d", op, fn, z_arr[3], o_arr[3], n);
        opcode = op;
        funct  = fn;
        foreach (inst_q[i]) exp_q.push_back(inst_q[i]);
        for (int c = 0; c < n; c++) begin
            alu_zero = z_arr[c];
            alu_ovf  = o_arr[c];
            @(posedge clock); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clock);
        n_checks++;
        if (act === blank(S_RESET)) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, act, blank(S_RESET));
    endtask

    task automatic release_reset;
        reset = 1'b0;
        begin
            obs_t e;
            e = blank(S_RESET);
            e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.reg_write = 1;
            exp_q.push_back(e);
        end
        mon_en = 1'b1;
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: got %h required nothing", act);
            end else begin
                obs_t e;
                e = exp_q.pop_front();
                if (act === e) n_pass++;
                else $display("FAIL cycle_state%0d: got %h required %h", e.st, act, e);
            end
        end
    end

    initial begin
        logic [5:0] rop, rfn;
        int k;
        // Held in reset from time zero: outputs must all be low.
        check_reset_outputs("reset_hold");
        @(posedge clock); #1;
        release_reset();

        run_instr(6'h00, 6'h20, -1, 0);
        run_instr(6'h00, 6'h20, -1, 1);
        run_instr(6'h00, 6'h22, -1, 1);
        run_instr(6'h00, 6'h24, -1, 1);
        run_instr(6'h08, 6'h11, -1, 0);
        run_instr(6'h08, 6'h11, -1, 1);
        run_instr(6'h23, 6'h00, -1, -1);
        run_instr(6'h2B, 6'h00, -1, -1);
        run_instr(6'h04, 6'h00, 1, -1);
        run_instr(6'h04, 6'h00, 0, -1);
        run_instr(6'h05, 6'h00, 1, -1);
        run_instr(6'h05, 6'h00, 0, -1);
        run_instr(6'h02, 6'h00, -1, -1);
        run_instr(6'h3F, 6'h20, -1, -1);
        run_instr(6'h00, 6'h08, -1, -1);

        // Reset pulse in the middle of an add: F, FW, D are checked, then
        // reset hits while in EXEC_R.
        for (int c = 0; c < 7; c++) begin z_arr[c] = 0; o_arr[c] = 1; end
        build(6'h00, 6'h20);
        $display("instr op=00 funct=20 interrupted by reset in EXEC_R");
        opcode = 6'h00; funct = 6'h20; alu_ovf = 1'b1;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(inst_q[c]);
            @(posedge clock); #1;
        end
        mon_en = 1'b0;
        reset  = 1'b1;
        check_reset_outputs("reset_mid_exec");
        @(posedge clock); #1;
        check_reset_outputs("reset_mid_exec_held");
        @(posedge clock); #1;
        release_reset();
        // The cleared ovf_q must not leak into this add's write-back.
        run_instr(6'h00, 6'h20, -1, 0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            rfn = 6'($urandom_range(0, 63));
            case (k)
                0, 9: begin rop = 6'h00; rfn = (rfn[0]) ? 6'h20 : (rfn[1] ? 6'h22 : 6'h24); end
                1: rop = 6'h08;
                2: rop = 6'h23;
                3: rop = 6'h2B;
                4: rop = 6'h04;
                5: rop = 6'h05;
                6: rop = 6'h02;
                7: rop = 6'h00;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, rfn, -1, -1);
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clock);
        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
